framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Write-side port of the 320x240x3b framebuffer: accepts pixel draw requests from the game/render
//  logic via valid/ready, buffers them in a small FIFO and issues one framebuffer write per cycle.
//  Optionally sweeps the whole buffer to CLEAR_COLOR on each new_frame pulse from output_module.
//  Color 0 is written like any other color (the display path treats it as transparent).
// PARAMETERS
//  FIFO_DEPTH   4      request FIFO entries, power of two, >=2
//  SCREEN_W     320    valid x range 0..SCREEN_W-1
//  SCREEN_H     240    valid y range 0..SCREEN_H-1
//  CLEAR_COLOR  3'd0   palette index written by the clear sweep
// PORTS
//  Clk          in   1    single clock domain
//  Reset        in   1    synchronous, active-low
//  new_frame    in   1    one-cycle pulse per frame (from output_module)
//  clear_en     in   1    1: start a clear sweep on each new_frame
//  pix_valid    in   1    draw request valid
//  pix_ready    out  1    request accepted when pix_valid & pix_ready
//  pix_coords   in   17   screenXY {x[8:0], y[7:0]}
//  pix_color    in   3    palette index
//  fb_we        out  1    framebuffer write strobe, registered
//  fb_coords    out  17   screenXY write address, registered
//  fb_data      out  3    write data, registered
//  clearing     out  1    high while sweep in progress
//  clear_overrun out 1    one-cycle pulse: new_frame arrived during a sweep
//  drop_count   out  16   saturating count of out-of-range requests
// BEHAVIOUR
//  Reset (Reset==0 at edge): FSM->RUN, FIFO empty, sweep counters 0; fb_we, clearing, clear_overrun,
//   pix_ready, drop_count, fb_coords, fb_data all 0. pix_ready rises the cycle after Reset releases.
//  pix_ready = Reset & !fifo_full (combinational); no push when full even if a pop occurs same cycle.
//  Accept: request with x>=SCREEN_W or y>=SCREEN_H is consumed but not enqueued; drop_count+1, holds
//   at 16'hFFFF. In-range requests enqueued in order.
//  FSM RUN: if FIFO non-empty, pop head; fb_we=1, fb_coords/fb_data = head on next edge. Latency:
//   accepted at edge N with FIFO empty -> fb_we high in cycle following edge N+1. Throughput 1/cycle.
//  FSM CLEAR: entered at edge where new_frame & clear_en in RUN; first sweep write (0,0) appears after
//   next edge. Raster order, x fastest: (0,0),(1,0)..(319,0),(0,1)..(319,239); one write per cycle,
//   fb_data=CLEAR_COLOR, exactly SCREEN_W*SCREEN_H writes. FIFO not popped during CLEAR; pushes continue
//   until full. After (319,239) written -> RUN; queued requests drain next, so draws land on top of clear.
//  clearing high from entry edge through cycle of last sweep write.
//  new_frame during CLEAR: ignored (sweep not restarted), clear_overrun pulses one cycle.
//  new_frame with clear_en=0: no effect. new_frame in RUN same cycle as a pop: pop completes, CLEAR next.
//  Reset mid-sweep: sweep abandoned, counters to 0, FSM RUN; queued requests lost.
//  fb_we=0 whenever no write issued; fb_coords/fb_data hold last value.
// STRUCTURE
//  structs.sv package: screenXY (existing), SCREEN_W/SCREEN_H constants, fbw_state_t enum {RUN,CLEAR}.
//  Sub-module pixel_write_fifo: sync FIFO, width 20 (screenXY+color), depth FIFO_DEPTH, push/pop/
//   full/empty, same Clk/active-low Reset. FSM, sweep counters, range check, drop counter in top.
// TESTING
//  Reset held 3 cycles, release -> all outputs 0 during reset; pix_ready=1 one cycle after release.
//  Push (10,20,c=5) into idle block -> exactly one fb_we, fb_coords=(10,20), fb_data=5, 2 cycles later.
//  Push (320,0),(0,240),(5,5) -> drop_count=2, only (5,5) written; pre-load 16'hFFFE, drop 3 -> FFFF.
//  clear_en=1, new_frame -> 76800 consecutive fb_we, first (0,0) last (319,239), all data 0, clearing high.
//  During sweep push 6 requests (depth 4) -> pix_ready drops after 4; 4 writes follow (319,239) in order.
//  new_frame mid-sweep -> clear_overrun pulse, sweep continues uninterrupted; Reset mid-sweep -> fb_we=0, RUN.

Source files
------------

// File: rtl/framebuffer_writer_pkg.sv
// Shared types and constants for the framebuffer write port.
package framebuffer_writer_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned COLOR_W  = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } screenXY;

  typedef struct packed {
    screenXY              xy;
    logic [COLOR_W-1:0]   color;
  } pix_req_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } fbw_state_t;

  function automatic logic xy_in_range(input screenXY p, input int unsigned w,
                                       input int unsigned h);
    return (32'(p.x) < w) && (32'(p.y) < h);
  endfunction

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// Small synchronous request FIFO between the draw interface and the write FSM.
module pixel_write_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Framebuffer write port: queued pixel draws plus an optional per-frame clear sweep.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SCREEN_W    = framebuffer_writer_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = framebuffer_writer_pkg::SCREEN_H,
  parameter logic [2:0]  CLEAR_COLOR = 3'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        new_frame,
  input  logic        clear_en,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [16:0] pix_coords,
  input  logic [2:0]  pix_color,
  output logic        fb_we,
  output logic [16:0] fb_coords,
  output logic [2:0]  fb_data,
  output logic        clearing,
  output logic        clear_overrun,
  output logic [15:0] drop_count
);

  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  fbw_state_t state;
  logic [8:0] sweep_x;
  logic [7:0] sweep_y;
  pix_req_t   req;
  pix_req_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       req_ok;
  logic       push;
  logic       pop;
  logic       sweep_last;

  assign req        = {pix_coords, pix_color};
  assign pix_ready  = Reset & ~fifo_full;
  assign accept     = pix_valid & pix_ready;
  assign req_ok     = xy_in_range(req.xy, SCREEN_W, SCREEN_H);
  assign push       = accept & req_ok;
  assign pop        = (state == RUN) & ~fifo_empty;
  assign sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);

  pixel_write_fifo #(
    .WIDTH (20),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Saturating count of consumed out-of-range requests.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      drop_count <= '0;
    end else if (accept && !req_ok && (drop_count != '1)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // RUN/CLEAR control and raster sweep counters (x fastest).
  // clearing falls one edge after leaving CLEAR so it covers the last sweep write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= RUN;
      sweep_x       <= '0;
      sweep_y       <= '0;
      clearing      <= 1'b0;
      clear_overrun <= 1'b0;
    end else begin
      clear_overrun <= 1'b0;
      case (state)
        RUN: begin
          if (new_frame && clear_en) begin
            state    <= CLEAR;
            clearing <= 1'b1;
            sweep_x  <= '0;
            sweep_y  <= '0;
          end else begin
            clearing <= 1'b0;
          end
        end
        CLEAR: begin
          clear_overrun <= new_frame;
          if (sweep_last) begin
            state   <= RUN;
            sweep_x <= '0;
            sweep_y <= '0;
          end else if (sweep_x == X_LAST) begin
            sweep_x <= '0;
            sweep_y <= sweep_y + 8'd1;
          end else begin
            sweep_x <= sweep_x + 9'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Registered framebuffer write port; address/data hold when idle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fb_we     <= 1'b0;
      fb_coords <= '0;
      fb_data   <= '0;
    end else if (state == CLEAR) begin
      fb_we     <= 1'b1;
      fb_coords <= {sweep_x, sweep_y};
      fb_data   <= CLEAR_COLOR;
    end else if (pop) begin
      fb_we     <= 1'b1;
      fb_coords <= head.xy;
      fb_data   <= head.color;
    end else begin
      fb_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: expected writes queued at drive time, compared per task.
module tb_framebuffer_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        new_frame = 1'b0;
  logic        clear_en = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [16:0] pix_coords = '0;
  logic [2:0]  pix_color = '0;
  logic        fb_we;
  logic [16:0] fb_coords;
  logic [2:0]  fb_data;
  logic        clearing;
  logic        clear_overrun;
  logic [15:0] drop_count;

  framebuffer_writer #(
    .FIFO_DEPTH  (4),
    .SCREEN_W    (320),
    .SCREEN_H    (240),
    .CLEAR_COLOR (3'd0)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .new_frame     (new_frame),
    .clear_en      (clear_en),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_coords    (pix_coords),
    .pix_color     (pix_color),
    .fb_we         (fb_we),
    .fb_coords     (fb_coords),
    .fb_data       (fb_data),
    .clearing      (clearing),
    .clear_overrun (clear_overrun),
    .drop_count    (drop_count)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned exp_drop = 0;
  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  int unsigned obs_t[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Records every write as {clearing, coords, data} with its cycle stamp.
  always @(posedge Clk) begin
    #1;
    if (fb_we === 1'b1) begin
      obs_q.push_back({clearing, fb_coords, fb_data});
      obs_t.push_back(cyc);
    end
  end

  function automatic logic [20:0] ent(input logic clr, input int unsigned x,
                                      input int unsigned y, input logic [2:0] c);
    return {clr, 9'(x), 8'(y), c};
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  // Drives one request and returns #1 after the accepting edge.
  task automatic send_req(input int unsigned x, input int unsigned y, input logic [2:0] c);
    @(negedge Clk);
    pix_valid  = 1'b1;
    pix_coords = {9'(x), 8'(y)};
    pix_color  = c;
    for (int i = 0; i < 200 && pix_ready !== 1'b1; i++) @(negedge Clk);
    if (pix_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout pix_ready=%b required=1", pix_ready);
    end else if (x < 320 && y < 240) begin
      exp_q.push_back(ent(1'b0, x, y, c));
    end
    @(posedge Clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_cmp++;
      if ({fb_we, clearing, clear_overrun, pix_ready, drop_count, fb_coords, fb_data} !== 40'd0) begin
        n_err++;
        $display("FAIL reset_outputs we=%b clr=%b ovr=%b rdy=%b drop=%h xy=%h d=%h required all 0",
                 fb_we, clearing, clear_overrun, pix_ready, drop_count, fb_coords, fb_data);
      end
    end
    Reset = 1'b1;
    exp_drop = 0;
    @(negedge Clk);
    n_cmp++;
    if (pix_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset pix_ready=%b required=1", pix_ready);
    end
  endtask

  task automatic test_single_write();
    int unsigned base;
    logic [20:0] e;
    clear_queues();
    @(negedge Clk);
    pix_valid  = 1'b1;
    pix_coords = {9'd10, 8'd20};
    pix_color  = 3'd5;
    n_cmp++;
    if (pix_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready pix_ready=%b required=1", pix_ready);
    end
    exp_q.push_back(ent(1'b0, 10, 20, 3'd5));
    @(posedge Clk); #1;
    base = cyc;
    pix_valid = 1'b0;
    repeat (4) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL single_count writes=%0d required=1", obs_q.size());
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q[0] !== e || obs_t[0] != base + 1) begin
        n_err++;
        $display("FAIL single_write got=%h@%0d required=%h@%0d", obs_q[0], obs_t[0], e, base + 1);
      end
    end
  endtask

  task automatic test_range();
    logic [20:0] e;
    clear_queues();
    send_req(320, 0, 3'd1);
    send_req(0, 240, 3'd2);
    send_req(319, 239, 3'd7);
    send_req(5, 5, 3'd3);
    exp_drop += 2;
    repeat (5) @(negedge Clk);
    n_cmp++;
    if (drop_count !== 16'(exp_drop)) begin
      n_err++;
      $display("FAIL drop_count got=%0d required=%0d", drop_count, exp_drop);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL range_count writes=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q[0] !== e) begin
        n_err++;
        $display("FAIL range_write got=%h required=%h", obs_q[0], e);
      end
      void'(obs_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    clear_queues();
    for (int k = 0; k < 8; k++) send_req(k * 37, k * 29, 3'(k));
    repeat (5) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_err++;
      $display("FAIL b2b_count writes=%0d required=8", obs_q.size());
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q[k] !== e || obs_t[k] != obs_t[0] + 32'(k)) begin
        n_err++;
        $display("FAIL b2b_write[%0d] got=%h@%0d required=%h@%0d", k, obs_q[k], obs_t[k], e,
                 obs_t[0] + 32'(k));
      end
    end
  endtask

  task automatic test_clear_disabled();
    clear_queues();
    clear_en = 1'b0;
    @(negedge Clk); new_frame = 1'b1;
    @(negedge Clk); new_frame = 1'b0;
    repeat (5) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != 0 || clearing !== 1'b0) begin
      n_err++;
      $display("FAIL clear_disabled writes=%0d clearing=%b required 0/0", obs_q.size(), clearing);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_queues();
    clear_en = 1'b1;
    @(negedge Clk); new_frame = 1'b1;
    @(negedge Clk); new_frame = 1'b0;
    repeat (50) @(negedge Clk);
    send_req(7, 8, 3'd2);
    send_req(9, 10, 3'd3);
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (fb_we !== 1'b0 || clearing !== 1'b0) begin
      n_err++;
      $display("FAIL midsweep_reset we=%b clearing=%b required 0/0", fb_we, clearing);
    end
    Reset = 1'b1;
    clear_en = 1'b0;
    exp_drop = 0;
    clear_queues();
    repeat (10) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != 0 || clearing !== 1'b0) begin
      n_err++;
      $display("FAIL midsweep_flush writes=%0d clearing=%b required 0/0", obs_q.size(), clearing);
    end
    send_req(11, 12, 3'd4);
    repeat (4) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== ent(1'b0, 11, 12, 3'd4)) begin
      n_err++;
      $display("FAIL midsweep_run writes=%0d first=%h required 1/%h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 21'h0, ent(1'b0, 11, 12, 3'd4));
    end
  endtask

  task automatic test_clear_sweep();
    int unsigned e_cyc;
    int          bad;
    int          first_bad;
    int          accepted;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    exp_drop = 0;
    @(negedge Clk);
    clear_queues();
    clear_en  = 1'b1;
    new_frame = 1'b1;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++) exp_q.push_back(ent(1'b1, x, y, 3'd0));
    @(posedge Clk); #1;
    e_cyc = cyc;
    new_frame = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (clearing !== 1'b1) begin
      n_err++;
      $display("FAIL clearing_entry clearing=%b required=1", clearing);
    end
    fork
      begin
        pix_valid  = 1'b1;
        pix_coords = {9'd400, 8'd0};
        pix_color  = 3'd1;
        for (int i = 1; i <= 65540; i++) begin
          @(negedge Clk);
          if (i == 100) new_frame = 1'b1;
          if (i == 101) begin
            new_frame = 1'b0;
            n_cmp++;
            if (clear_overrun !== 1'b1) begin
              n_err++;
              $display("FAIL overrun_pulse clear_overrun=%b required=1", clear_overrun);
            end
          end
          if (i == 102) begin
            n_cmp++;
            if (clear_overrun !== 1'b0) begin
              n_err++;
              $display("FAIL overrun_width clear_overrun=%b required=0", clear_overrun);
            end
          end
          if (i == 65534) begin
            n_cmp++;
            if (drop_count !== 16'hFFFE) begin
              n_err++;
              $display("FAIL drop_near_sat got=%h required=fffe", drop_count);
            end
          end
        end
        pix_valid = 1'b0;
        n_cmp++;
        if (drop_count !== 16'hFFFF) begin
          n_err++;
          $display("FAIL drop_saturate got=%h required=ffff", drop_count);
        end
        repeat (10000) @(negedge Clk);
        n_cmp++;
        if (clearing !== 1'b1) begin
          n_err++;
          $display("FAIL clearing_mid clearing=%b required=1", clearing);
        end
        accepted = 0;
        for (int t = 0; t < 10; t++) begin
          pix_valid  = 1'b1;
          pix_coords = {9'(20 + accepted), 8'(30 + accepted)};
          pix_color  = 3'(accepted + 1);
          if (pix_ready === 1'b1) begin
            exp_q.push_back(ent(1'b0, 20 + accepted, 30 + accepted, 3'(accepted + 1)));
            accepted++;
          end
          @(negedge Clk);
        end
        pix_valid = 1'b0;
        n_cmp++;
        if (accepted != 4 || pix_ready !== 1'b0) begin
          n_err++;
          $display("FAIL fifo_full_ready accepted=%0d ready=%b required 4/0", accepted, pix_ready);
        end
      end
      begin
        for (int t = 0; t < 80000 && clearing !== 1'b0; t++) @(negedge Clk);
        if (clearing !== 1'b0) begin
          n_cmp++; n_err++;
          $display("FAIL sweep_timeout clearing=%b required=0", clearing);
        end
      end
    join
    repeat (10) @(negedge Clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL sweep_count writes=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      if (obs_q[k] !== exp_q[k] || obs_t[k] != e_cyc + 1 + 32'(k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL sweep_stream bad=%0d first@%0d got=%h@%0d required=%h@%0d", bad, first_bad,
               obs_q[first_bad], obs_t[first_bad], exp_q[first_bad], e_cyc + 1 + 32'(first_bad));
    end
    n_cmp++;
    if (clearing !== 1'b0 || fb_we !== 1'b0 || drop_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sweep_end clearing=%b we=%b drop=%h required 0/0/ffff",
               clearing, fb_we, drop_count);
    end
    clear_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_range();
    test_back_to_back();
    test_clear_disabled();
    test_reset_mid_sweep();
    test_clear_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog sim_time=%0t required finish before 1500000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
